// File: rtl/pwm_spi_pkg.sv
// Shared types and helpers for the SPI-commanded PWM motor driver.
// Channel command word layout and frame width helper.
package pwm_spi_pkg;

  localparam int unsigned DUTY_W = 7;

  localparam logic DIR_FWD = 1'b1;
  localparam logic DIR_REV = 1'b0;

  typedef struct packed {
    logic              dir;
    logic [DUTY_W-1:0] duty;
  } chan_cmd_t;

  function automatic int unsigned frame_w(
    input int unsigned n_ch,
    input int unsigned duty_w
  );
    return n_ch * (duty_w + 1);
  endfunction

endpackage

// File: rtl/spi_frame_rx.sv
// Oversampled SPI frame receiver: input syncs, shift register,
// bit counter, commit pulse and frame error pulse.
module spi_frame_rx
  import pwm_spi_pkg::*;
#(
  parameter  int unsigned N_CH   = 2,
  parameter  int unsigned DUTY_W = 7,
  localparam int unsigned FW     = frame_w(N_CH, DUTY_W)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          sck,
  input  logic          sdi,
  input  logic          load,
  output logic          sdo,
  output logic [FW-1:0] frame,
  output logic          commit,
  output logic          frame_err
);

  localparam int unsigned CNT_W = $clog2(FW + 2);

  logic [1:0]       sck_q;
  logic [1:0]       sdi_q;
  logic [1:0]       load_q;
  logic             sck_d;
  logic             load_d;
  logic [CNT_W-1:0] cnt;
  logic             sck_rise;
  logic             sck_fall;
  logic             load_rise;
  logic             load_fall;

  assign sck_rise  = sck_q[1] & ~sck_d;
  assign sck_fall  = ~sck_q[1] & sck_d;
  assign load_rise = load_q[1] & ~load_d;
  assign load_fall = ~load_q[1] & load_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      sck_q     <= '0;
      sdi_q     <= '0;
      load_q    <= '0;
      sck_d     <= 1'b0;
      load_d    <= 1'b0;
      cnt       <= '0;
      frame     <= '0;
      sdo       <= 1'b0;
      commit    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      sck_q  <= {sck_q[0], sck};
      sdi_q  <= {sdi_q[0], sdi};
      load_q <= {load_q[0], load};
      sck_d  <= sck_q[1];
      load_d <= load_q[1];

      if (load_rise) begin
        cnt <= '0;
      end else if (sck_rise && load_q[1]) begin
        frame <= {frame[FW-2:0], sdi_q[1]};
        if (cnt != CNT_W'(FW + 1))
          cnt <= cnt + 1'b1;
      end

      // Readback lags one half-bit so the MCU sees the prior frame.
      if (sck_fall)
        sdo <= frame[FW-1];

      commit    <= load_fall && (cnt == CNT_W'(FW));
      frame_err <= load_fall && (cnt != CNT_W'(FW));
    end
  end

endmodule

// File: rtl/spi_pwm_motor_array.sv
// N-channel SPI-commanded H-bridge PWM driver.
// Optional watchdog failsafe: define SPI_PWM_WDOG_EN.
module spi_pwm_motor_array
  import pwm_spi_pkg::*;
#(
  parameter int unsigned N_CH         = 2,
  parameter int unsigned DUTY_W       = 7,
  parameter int unsigned PRESCALE     = 51,
  parameter int unsigned WDOG_PERIODS = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sck,
  input  logic              sdi,
  input  logic              load,
  output logic              sdo,
  output logic [N_CH-1:0]   enable,
  output logic [2*N_CH-1:0] a,
  output logic              frame_err,
  output logic              debug_light
);

  localparam int unsigned FW    = frame_w(N_CH, DUTY_W);
  localparam int unsigned CW    = DUTY_W + 1;
  localparam int unsigned PMAX  = (1 << DUTY_W) - 1;
  localparam int unsigned PRE_W =
    (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [FW-1:0]     rx_frame;
  logic              rx_commit;
  logic [PRE_W-1:0]  pre_cnt;
  logic [PRE_W-1:0]  pre_nxt;
  logic [DUTY_W-1:0] pwm_cnt;
  logic [DUTY_W-1:0] pwm_nxt;
  logic              tick;
  logic              bnd;
  logic              wdog_trip;

  logic [N_CH-1:0]   rx_dir;
  logic [N_CH-1:0]   pend_dir;
  logic [N_CH-1:0]   pend_dir_nxt;
  logic [N_CH-1:0]   act_dir;
  logic [N_CH-1:0]   act_dir_nxt;
  logic [N_CH-1:0]   en_nxt;
  logic [2*N_CH-1:0] a_nxt;
  logic [DUTY_W-1:0] rx_duty      [N_CH];
  logic [DUTY_W-1:0] pend_duty    [N_CH];
  logic [DUTY_W-1:0] pend_duty_nxt[N_CH];
  logic [DUTY_W-1:0] act_duty     [N_CH];
  logic [DUTY_W-1:0] act_duty_nxt [N_CH];

  spi_frame_rx #(
    .N_CH   (N_CH),
    .DUTY_W (DUTY_W)
  ) u_rx (
    .clk       (clk),
    .reset     (reset),
    .sck       (sck),
    .sdi       (sdi),
    .load      (load),
    .sdo       (sdo),
    .frame     (rx_frame),
    .commit    (rx_commit),
    .frame_err (frame_err)
  );

  always_comb begin
    tick    = (pre_cnt == PRE_W'(PRESCALE - 1));
    bnd     = tick && (pwm_cnt == DUTY_W'(PMAX - 1));
    pre_nxt = tick ? '0 : pre_cnt + 1'b1;
    pwm_nxt = pwm_cnt;
    if (bnd)
      pwm_nxt = '0;
    else if (tick)
      pwm_nxt = pwm_cnt + 1'b1;

    rx_dir        = '0;
    pend_dir_nxt  = '0;
    act_dir_nxt   = '0;
    en_nxt        = '0;
    a_nxt         = '0;
    rx_duty       = '{default: '0};
    pend_duty_nxt = '{default: '0};
    act_duty_nxt  = '{default: '0};

    for (int i = 0; i < N_CH; i++) begin
      rx_dir[i]  = rx_frame[(N_CH-1-i)*CW + DUTY_W];
      rx_duty[i] = rx_frame[(N_CH-1-i)*CW +: DUTY_W];

      pend_dir_nxt[i]  = rx_commit ? rx_dir[i] : pend_dir[i];
      pend_duty_nxt[i] = rx_commit ? rx_duty[i] :
                         wdog_trip ? '0 : pend_duty[i];

      // Reload only at the period boundary to keep pulses whole.
      act_dir_nxt[i]  = bnd ? pend_dir_nxt[i]  : act_dir[i];
      act_duty_nxt[i] = bnd ? pend_duty_nxt[i] : act_duty[i];

      en_nxt[i] = (pwm_nxt < act_duty_nxt[i]);
      if (act_duty_nxt[i] != '0)
        a_nxt[2*i +: 2] = {act_dir_nxt[i] == DIR_FWD,
                           act_dir_nxt[i] == DIR_REV};
    end
  end

`ifdef SPI_PWM_WDOG_EN
  localparam int unsigned WD_W = $clog2(WDOG_PERIODS + 1);

  logic [WD_W-1:0] wdog_cnt;

  assign wdog_trip = bnd && !rx_commit &&
                     (wdog_cnt >= WD_W'(WDOG_PERIODS - 1));

  always_ff @(posedge clk) begin
    if (reset)
      wdog_cnt <= '0;
    else if (rx_commit)
      wdog_cnt <= '0;
    else if (bnd && wdog_cnt != WD_W'(WDOG_PERIODS))
      wdog_cnt <= wdog_cnt + 1'b1;
  end
`else
  logic unused_wdog;

  assign wdog_trip   = 1'b0;
  assign unused_wdog = ^WDOG_PERIODS;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_cnt     <= '0;
      pwm_cnt     <= '0;
      pend_dir    <= '0;
      act_dir     <= '0;
      enable      <= '0;
      a           <= '0;
      debug_light <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        pend_duty[i] <= '0;
        act_duty[i]  <= '0;
      end
    end else begin
      pre_cnt     <= pre_nxt;
      pwm_cnt     <= pwm_nxt;
      pend_dir    <= pend_dir_nxt;
      act_dir     <= act_dir_nxt;
      enable      <= en_nxt;
      a           <= a_nxt;
      debug_light <= debug_light ^ rx_commit;
      for (int i = 0; i < N_CH; i++) begin
        pend_duty[i] <= pend_duty_nxt[i];
        act_duty[i]  <= act_duty_nxt[i];
      end
    end
  end

endmodule

// File: tb/tb_spi_pwm_motor_array.sv
// Self-checking bench for spi_pwm_motor_array (N_CH=2, DUTY_W=7, PRESCALE=2).
// Define SPI_PWM_WDOG_EN to also exercise the watchdog with WDOG_PERIODS=4.
module tb_spi_pwm_motor_array;
  import pwm_spi_pkg::*;

  localparam int NCH   = 2;
  localparam int PRE   = 2;
  localparam int TICKS = 127;
  localparam int PER   = PRE * TICKS;
  localparam int FW    = 16;
`ifdef SPI_PWM_WDOG_EN
  localparam int WDP = 4;
`else
  localparam int WDP = 64;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       sck;
  logic       sdi;
  logic       load;
  logic       sdo;
  logic [1:0] enable;
  logic [3:0] a;
  logic       frame_err;
  logic       debug_light;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  int         pos, cd, wd, m_tog, m_errs, err_seen;
  bit         m_applied;
  logic [15:0] m_stage;
  chan_cmd_t  m_pend[NCH];
  chan_cmd_t  m_act[NCH];
  logic [1:0] exp_en;
  logic [3:0] exp_a;

  // window scratch
  int         mm, hi0, hi1;
  logic [5:0] got, want;

  spi_pwm_motor_array #(
    .N_CH         (NCH),
    .DUTY_W       (7),
    .PRESCALE     (PRE),
    .WDOG_PERIODS (WDP)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sck         (sck),
    .sdi         (sdi),
    .load        (load),
    .sdo         (sdo),
    .enable      (enable),
    .a           (a),
    .frame_err   (frame_err),
    .debug_light (debug_light)
  );

  always #5 clk = ~clk;

  // Free-running PWM phase is a pure function of cycles since reset.
  always @(posedge clk) begin
    if (reset) begin
      pos = 0;
      cd  = 0;
      wd  = 0;
      for (int i = 0; i < NCH; i++) begin
        m_pend[i] = '0;
        m_act[i]  = '0;
      end
    end else begin
      m_applied = 1'b0;
      pos++;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          for (int i = 0; i < NCH; i++)
            m_pend[i] = chan_cmd_t'(m_stage[(NCH-1-i)*8 +: 8]);
          m_applied = 1'b1;
        end
      end
`ifdef SPI_PWM_WDOG_EN
      if (m_applied)
        wd = 0;
      else if (pos % PER == 0) begin
        if (wd < WDP) wd++;
        if (wd == WDP)
          for (int i = 0; i < NCH; i++) m_pend[i].duty = '0;
      end
`endif
      if (pos % PER == 0)
        m_act = m_pend;
    end
    for (int i = 0; i < NCH; i++) begin
      exp_en[i] = ((pos / PRE) % TICKS) < int'(m_act[i].duty);
      if (m_act[i].duty == 0)
        exp_a[2*i +: 2] = 2'b00;
      else
        exp_a[2*i +: 2] = (m_act[i].dir == DIR_FWD) ? 2'b10 : 2'b01;
    end
  end

  always @(negedge clk)
    if (reset !== 1'b1 && frame_err === 1'b1) err_seen++;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_bnd();
    int k = 0;
    do begin
      tick(1);
      k++;
    end while (pos % PER != 0 && k < 2 * PER);
  endtask

  // MCU side: shift nb bits MSB first, reading sdo before each rise.
  task automatic send(input logic [31:0] w, input int nb,
                      output logic [31:0] rd);
    rd   = '0;
    load = 1'b1;
    tick(3);
    for (int k = nb - 1; k >= 0; k--) begin
      sdi = w[k];
      tick(3);
      rd  = {rd[30:0], sdo};
      sck = 1'b1;
      tick(3);
      sck = 1'b0;
    end
    tick(3);
    load = 1'b0;
    if (nb == FW) begin
      m_stage = w[15:0];
      cd      = 4;
      m_tog++;
    end else begin
      m_errs++;
    end
    tick(4);
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    reset = 1'b1; sck = 1'b0; sdi = 1'b0; load = 1'b0;
    m_tog = 0; m_errs = 0; err_seen = 0;
    tick(4);
    @(negedge clk);
    n_tests++;
    if ({enable, a, sdo, frame_err, debug_light} !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want 0",
               {enable, a, sdo, frame_err, debug_light});
    end
    reset = 1'b0;
    tick(2);
    load = 1'b1;
    tick(3);
    for (int k = 0; k < 5; k++) begin
      sdi = 1'($urandom);
      tick(3);
      sck = 1'b1;
      tick(3);
      sck = 1'b0;
    end
    reset = 1'b1; load = 1'b0; sck = 1'b0;
    m_tog = 0;
    tick(3);
    @(negedge clk);
    n_tests++;
    if ({enable, a, sdo, frame_err, debug_light} !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_midframe: got %b want 0",
               {enable, a, sdo, frame_err, debug_light});
    end
    reset = 1'b0; sdi = 1'b0;
    tick(2);
    send({16'd0, 1'($urandom), 7'($urandom_range(1, 126)),
          1'($urandom), 7'($urandom_range(1, 126))}, FW, rd);
    wait_bnd();
    mm = 0;
    repeat (PER) begin
      @(negedge clk);
      if (enable !== exp_en || a !== exp_a) begin
        mm++; got = {enable, a}; want = {exp_en, exp_a};
      end
    end
    n_tests++;
    if (mm != 0) begin
      n_fail++;
      $display("FAIL reset_recover: %0d bad cycles, got %b want %b",
               mm, got, want);
    end
    n_tests++;
    if (err_seen != m_errs) begin
      n_fail++;
      $display("FAIL reset_no_err: got %0d want %0d", err_seen, m_errs);
    end
    n_tests++;
    if (debug_light !== m_tog[0]) begin
      n_fail++;
      $display("FAIL reset_dbg: got %b want %b", debug_light, m_tog[0]);
    end
  endtask

  task automatic test_good_frame();
    logic [31:0] rd;
    logic        d0 = debug_light;
    send({16'd0, 1'b1, 7'd32, 1'b0, 7'd127}, FW, rd);
    wait_bnd();
    mm = 0; hi0 = 0; hi1 = 0;
    repeat (PER) begin
      @(negedge clk);
      if (enable !== exp_en || a !== exp_a) begin
        mm++; got = {enable, a}; want = {exp_en, exp_a};
      end
      hi0 += int'(enable[0]);
      hi1 += int'(enable[1]);
    end
    n_tests++;
    if (mm != 0) begin
      n_fail++;
      $display("FAIL good_model: %0d bad cycles, got %b want %b",
               mm, got, want);
    end
    n_tests++;
    if (hi0 != 32 * PRE) begin
      n_fail++;
      $display("FAIL good_duty0: got %0d high clk want %0d", hi0, 32 * PRE);
    end
    n_tests++;
    if (hi1 != PER) begin
      n_fail++;
      $display("FAIL good_duty1: got %0d high clk want %0d", hi1, PER);
    end
    n_tests++;
    if (a !== 4'b0110) begin
      n_fail++;
      $display("FAIL good_dir: got %b want 0110", a);
    end
    n_tests++;
    if (debug_light !== ~d0) begin
      n_fail++;
      $display("FAIL good_dbg: got %b want %b", debug_light, ~d0);
    end
  endtask

  task automatic test_bad_frames();
    logic [31:0] rd;
    logic        d0 = debug_light;
    int          e0 = err_seen;
    send($urandom, 13, rd);
    send($urandom, 15, rd);
    tick(2);
    n_tests++;
    if (err_seen - e0 != 2) begin
      n_fail++;
      $display("FAIL bad_err_pulses: got %0d want 2", err_seen - e0);
    end
    n_tests++;
    if (debug_light !== d0) begin
      n_fail++;
      $display("FAIL bad_dbg: got %b want %b", debug_light, d0);
    end
    mm = 0;
    repeat (PER) begin
      @(negedge clk);
      if (enable !== exp_en || a !== exp_a) begin
        mm++; got = {enable, a}; want = {exp_en, exp_a};
      end
    end
    n_tests++;
    if (mm != 0) begin
      n_fail++;
      $display("FAIL bad_hold: %0d bad cycles, got %b want %b",
               mm, got, want);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    int          k = 0;
    while (pos % PER != 2 && k < 2 * PER) begin
      tick(1);
      k++;
    end
    send({16'd0, 1'($urandom), 7'd10, 8'($urandom)}, FW, rd);
    send({16'd0, 1'($urandom), 7'd90, 8'($urandom)}, FW, rd);
    mm = 0;
    repeat (PER) begin
      @(negedge clk);
      if (enable !== exp_en || a !== exp_a) begin
        mm++; got = {enable, a}; want = {exp_en, exp_a};
      end
    end
    n_tests++;
    if (mm != 0) begin
      n_fail++;
      $display("FAIL b2b_transition: %0d bad cycles, got %b want %b",
               mm, got, want);
    end
    hi0 = 0;
    repeat (PER) begin
      @(negedge clk);
      hi0 += int'(enable[0]);
    end
    n_tests++;
    if (hi0 != 90 * PRE) begin
      n_fail++;
      $display("FAIL b2b_duty: got %0d high clk want %0d", hi0, 90 * PRE);
    end
  endtask

  task automatic test_coast_sdo();
    logic [31:0] rd;
    logic [31:0] f = {16'd0, 1'b1, 7'd0, 8'($urandom)};
    send(f, FW, rd);
    wait_bnd();
    mm = 0; hi0 = 0;
    repeat (PER) begin
      @(negedge clk);
      if (enable !== exp_en || a !== exp_a) begin
        mm++; got = {enable, a}; want = {exp_en, exp_a};
      end
      hi0 += int'(enable[0]);
    end
    n_tests++;
    if (mm != 0 || hi0 != 0 || a[1:0] !== 2'b00) begin
      n_fail++;
      $display("FAIL coast: %0d bad, en0 high %0d, a0 %b want 0/0/00",
               mm, hi0, a[1:0]);
    end
    send($urandom & 32'hffff, FW, rd);
    n_tests++;
    if (rd[15:0] !== f[15:0]) begin
      n_fail++;
      $display("FAIL sdo_readback: got %h want %h", rd[15:0], f[15:0]);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd;
    logic [6:0]  d0;
    repeat (3) begin
      d0 = 7'($urandom_range(0, 127));
      send({16'd0, 1'($urandom), d0, 8'($urandom)}, FW, rd);
      wait_bnd();
      mm = 0; hi0 = 0;
      repeat (PER) begin
        @(negedge clk);
        if (enable !== exp_en || a !== exp_a) begin
          mm++; got = {enable, a}; want = {exp_en, exp_a};
        end
        hi0 += int'(enable[0]);
      end
      n_tests++;
      if (mm != 0 || hi0 != int'(d0) * PRE) begin
        n_fail++;
        $display("FAIL random_d%0d: %0d bad, high %0d want %0d, got %b want %b",
                 d0, mm, hi0, int'(d0) * PRE, got, want);
      end
    end
  endtask

`ifdef SPI_PWM_WDOG_EN
  task automatic test_wdog();
    logic [31:0] rd;
    send({16'd0, 1'($urandom), 7'($urandom_range(1, 126)),
          1'($urandom), 7'($urandom_range(1, 126))}, FW, rd);
    wait_bnd();
    mm = 0;
    repeat (3 * PER) begin
      @(negedge clk);
      if (enable !== exp_en || a !== exp_a) begin
        mm++; got = {enable, a}; want = {exp_en, exp_a};
      end
    end
    n_tests++;
    if (mm != 0) begin
      n_fail++;
      $display("FAIL wdog_hold: %0d bad cycles, got %b want %b",
               mm, got, want);
    end
    tick(2);
    @(negedge clk);
    n_tests++;
    if ({enable, a} !== 6'd0) begin
      n_fail++;
      $display("FAIL wdog_trip: got %b want 0", {enable, a});
    end
    send({16'd0, 1'b1, 7'd50, 1'b0, 7'd20}, FW, rd);
    wait_bnd();
    mm = 0; hi0 = 0;
    repeat (PER) begin
      @(negedge clk);
      if (enable !== exp_en || a !== exp_a) begin
        mm++; got = {enable, a}; want = {exp_en, exp_a};
      end
      hi0 += int'(enable[0]);
    end
    n_tests++;
    if (mm != 0 || hi0 != 50 * PRE) begin
      n_fail++;
      $display("FAIL wdog_rearm: %0d bad, high %0d want %0d",
               mm, hi0, 50 * PRE);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_good_frame();
    test_bad_frames();
    test_back_to_back();
    test_coast_sdo();
    test_random();
`ifdef SPI_PWM_WDOG_EN
    test_wdog();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
